jstk_cursor_ctrl: RTL and testbench



---
 rtl/jstk_cursor_ctrl.sv | 172 +++++++++++++++++
 tb/tb_jstk_cursor_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_cursor_ctrl.sv
// Joystick input conditioning: axis decode, per-axis press/hold auto-repeat cursor,
// and single-cycle place/fire strobes from joystick buttons and a debounced board button.
module jstk_cursor_ctrl #(
    parameter int unsigned GRID_N      = 9,
    parameter int unsigned LOW_TH      = 350,
    parameter int unsigned HIGH_TH     = 650,
    parameter int unsigned REPEAT_DLY  = 25000000,
    parameter int unsigned REPEAT_RATE = 10000000,
    parameter int unsigned DEB_CYCLES  = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [39:0] jstk_data,
    input  logic        btnr,
    input  logic        enable,
    output logic [3:0]  sel_row,
    output logic [3:0]  sel_col,
    output logic        place_pulse,
    output logic        fire_pulse
);

    typedef enum logic [1:0] {DirNone, DirNeg, DirPos} dir_e;
    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

    localparam logic [3:0] CenterPos = 4'(GRID_N / 2);
    localparam logic [3:0] MaxPos    = 4'(GRID_N - 1);

    logic [1:0][9:0] axis_val;
    logic [1:0][3:0] axis_pos;

    // Axis 0 is x (drives the column), axis 1 is y (drives the row).
    assign axis_val[0] = {jstk_data[9:8], jstk_data[23:16]};
    assign axis_val[1] = {jstk_data[25:24], jstk_data[39:32]};

    logic unused_bits;
    assign unused_bits = ^{jstk_data[31:26], jstk_data[15:10], jstk_data[7:3], jstk_data[1]};

    function automatic logic [3:0] step_pos(input logic [3:0] p, input dir_e d);
        logic [3:0] r;
        r = p;
        if (d == DirNeg && p != 4'd0) begin
            r = p - 4'd1;
        end else if (d == DirPos && p != MaxPos) begin
            r = p + 4'd1;
        end
        return r;
    endfunction

    for (genvar a = 0; a < 2; a++) begin : g_axis
        dir_e        dir_d;
        dir_e        dir_q;
        dir_e        last_q;
        state_e      st_q;
        logic [31:0] cnt_q;
        logic [31:0] limit;
        logic [3:0]  pos_q;

        // Direction is squashed while disabled so a held deflection re-presses on enable.
        always_comb begin
            dir_d = DirNone;
            if (enable) begin
                if ({22'd0, axis_val[a]} < LOW_TH) begin
                    dir_d = DirNeg;
                end else if ({22'd0, axis_val[a]} > HIGH_TH) begin
                    dir_d = DirPos;
                end
            end
        end

        assign limit = (st_q == StDelay) ? 32'(REPEAT_DLY - 1) : 32'(REPEAT_RATE - 1);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dir_q  <= DirNone;
                last_q <= DirNone;
                st_q   <= StIdle;
                cnt_q  <= '0;
                pos_q  <= CenterPos;
            end else begin
                dir_q <= dir_d;
                if (!enable) begin
                    st_q  <= StIdle;
                    cnt_q <= '0;
                end else begin
                    unique case (st_q)
                        StIdle: begin
                            cnt_q <= '0;
                            if (dir_q != DirNone) begin
                                pos_q  <= step_pos(pos_q, dir_q);
                                last_q <= dir_q;
                                st_q   <= StDelay;
                            end
                        end
                        StDelay, StRepeat: begin
                            if (dir_q == DirNone) begin
                                st_q  <= StIdle;
                                cnt_q <= '0;
                            end else if (dir_q != last_q) begin
                                pos_q  <= step_pos(pos_q, dir_q);
                                last_q <= dir_q;
                                cnt_q  <= '0;
                                st_q   <= StDelay;
                            end else if (cnt_q == limit) begin
                                pos_q <= step_pos(pos_q, dir_q);
                                cnt_q <= '0;
                                st_q  <= StRepeat;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        default: begin
                            st_q  <= StIdle;
                            cnt_q <= '0;
                        end
                    endcase
                end
            end
        end

        assign axis_pos[a] = pos_q;
    end

    assign sel_col = axis_pos[0];
    assign sel_row = axis_pos[1];

    logic        prev_c_q;
    logic        prev_z_q;
    logic [1:0]  sync_q;
    logic        acc_q;
    logic        acc_prev_q;
    logic [31:0] deb_cnt_q;
    logic        place_q;
    logic        fire_q;
    logic        place_d;
    logic        fire_d;

    assign place_d = enable & ((jstk_data[0] & ~prev_c_q) | (acc_q & ~acc_prev_q));
    assign fire_d  = enable & jstk_data[2] & ~prev_z_q;

    // History and debounce keep running while disabled so held buttons never pulse on enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_c_q   <= 1'b0;
            prev_z_q   <= 1'b0;
            sync_q     <= '0;
            acc_q      <= 1'b0;
            acc_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
            place_q    <= 1'b0;
            fire_q     <= 1'b0;
        end else begin
            prev_c_q   <= jstk_data[0];
            prev_z_q   <= jstk_data[2];
            sync_q     <= {sync_q[0], btnr};
            acc_prev_q <= acc_q;
            if (sync_q[1] == acc_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == 32'(DEB_CYCLES - 1)) begin
                acc_q     <= sync_q[1];
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 32'd1;
            end
            place_q <= place_d;
            fire_q  <= fire_d;
        end
    end

    assign place_pulse = place_q;
    assign fire_pulse  = fire_q;

endmodule

// File: tb/tb_jstk_cursor_ctrl.sv
// Self-checking bench for jstk_cursor_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a run-length based reference model.
module tb_jstk_cursor_ctrl;

    localparam int GridN = 9;
    localparam int LowTh = 350;
    localparam int HighTh = 650;
    localparam int RptDly = 8;
    localparam int RptRate = 4;
    localparam int DebCyc = 3;

    logic        clk;
    logic        reset_n;
    logic [39:0] jstk_data;
    logic        btnr;
    logic        enable;
    logic [3:0]  sel_row;
    logic [3:0]  sel_col;
    logic        place_pulse;
    logic        fire_pulse;

    logic [9:0] x_v;
    logic [9:0] y_v;
    logic       c_v;
    logic       z_v;

    int checks = 0;
    int errors = 0;

    jstk_cursor_ctrl #(
        .GRID_N     (GridN),
        .LOW_TH     (LowTh),
        .HIGH_TH    (HighTh),
        .REPEAT_DLY (RptDly),
        .REPEAT_RATE(RptRate),
        .DEB_CYCLES (DebCyc)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .jstk_data  (jstk_data),
        .btnr       (btnr),
        .enable     (enable),
        .sel_row    (sel_row),
        .sel_col    (sel_col),
        .place_pulse(place_pulse),
        .fire_pulse (fire_pulse)
    );

    always_comb begin
        jstk_data = {y_v[7:0], 6'd0, y_v[9:8], x_v[7:0], 6'd0, x_v[9:8], 5'd0, z_v, 1'b0, c_v};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- reference model ----------------
    // A deflection run of length k (cycles the FSM has seen the same direction) steps on
    // k = 1, k = RptDly+1 and every RptRate cycles after that.
    function automatic int decode(input int v);
        if (v < LowTh) return 1;
        if (v > HighTh) return 2;
        return 0;
    endfunction

    int m_k[2];
    int m_last[2];
    int m_pos[2];
    int m_dprev[2];
    bit m_en_prev, m_c_prev, m_z_prev, m_acc, m_acc_prev;
    bit m_bh[1:4];
    int e_row, e_col, e_place, e_fire;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < 2; a++) begin
                m_k[a] = 0;
                m_last[a] = 0;
                m_pos[a] = GridN / 2;
                m_dprev[a] = 0;
            end
            m_en_prev = 0; m_c_prev = 0; m_z_prev = 0; m_acc = 0; m_acc_prev = 0;
            for (int i = 1; i <= 4; i++) m_bh[i] = 0;
            e_row = GridN / 2; e_col = GridN / 2; e_place = 0; e_fire = 0;
        end else begin
            for (int a = 0; a < 2; a++) begin
                int eff;
                eff = (enable && m_en_prev) ? m_dprev[a] : 0;
                if (eff != 0 && eff == m_last[a]) m_k[a]++;
                else m_k[a] = (eff != 0) ? 1 : 0;
                m_last[a] = eff;
                if (m_k[a] == 1 || m_k[a] == RptDly + 1 ||
                    (m_k[a] > RptDly + 1 && (m_k[a] - RptDly - 1) % RptRate == 0)) begin
                    if (eff == 1 && m_pos[a] > 0) m_pos[a]--;
                    if (eff == 2 && m_pos[a] < GridN - 1) m_pos[a]++;
                end
            end
            e_place = (enable && ((c_v && !m_c_prev) || (m_acc && !m_acc_prev))) ? 1 : 0;
            e_fire = (enable && z_v && !m_z_prev) ? 1 : 0;
            // Board button is accepted once its (2-cycle delayed) level held DebCyc cycles.
            m_acc_prev = m_acc;
            if (m_bh[2] == m_bh[3] && m_bh[3] == m_bh[4]) m_acc = m_bh[2];
            m_bh[4] = m_bh[3]; m_bh[3] = m_bh[2]; m_bh[2] = m_bh[1]; m_bh[1] = btnr;
            m_dprev[0] = decode(int'(x_v));
            m_dprev[1] = decode(int'(y_v));
            m_en_prev = enable; m_c_prev = c_v; m_z_prev = z_v;
            e_col = m_pos[0];
            e_row = m_pos[1];
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("model_row", int'(sel_row), e_row);
            chk("model_col", int'(sel_col), e_col);
            chk("model_place", int'(place_pulse), e_place);
            chk("model_fire", int'(fire_pulse), e_fire);
        end
    end

    // ---------------- stimulus ----------------
    int cnt;
    int exp_v;

    initial begin
        reset_n = 1'b0; x_v = 10'd512; y_v = 10'd512; c_v = 1'b0; z_v = 1'b0;
        btnr = 1'b0; enable = 1'b1;
        tick(3);
        reset_n = 1'b1;

        // Idle after reset
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            cnt += int'(place_pulse) + int'(fire_pulse);
        end
        chk("idle_row", int'(sel_row), 4);
        chk("idle_col", int'(sel_col), 4);
        chk("idle_pulses", cnt, 0);

        // Left hold: first step, delay, repeat, saturation at 0
        x_v = 10'd100;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            exp_v = (i < 2) ? 4 : (i < 10) ? 3 : (i < 14) ? 2 : (i < 18) ? 1 : 0;
            chk("left_hold_col", int'(sel_col), exp_v);
        end
        x_v = 10'd512;
        tick(5);

        // Asynchronous reset in the middle of an auto-repeat
        x_v = 10'd900;
        tick(12);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_row", int'(sel_row), 4);
        chk("async_rst_col", int'(sel_col), 4);
        chk("async_rst_place", int'(place_pulse), 0);
        chk("async_rst_fire", int'(fire_pulse), 0);
        tick(2);
        x_v = 10'd512;
        reset_n = 1'b1;
        tick(3);

        // Down then flip to up while in the delay window
        y_v = 10'd900;
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) y_v = 10'd100;
            tick(1);
            exp_v = (i < 2) ? 4 : (i < 6) ? 5 : (i < 14) ? 4 : 3;
            chk("flip_row", int'(sel_row), exp_v);
        end
        y_v = 10'd512;
        tick(3);

        // Values exactly at the thresholds do not move the cursor
        x_v = 10'd350; y_v = 10'd650;
        tick(20);
        x_v = 10'd650; y_v = 10'd350;
        tick(20);
        chk("thresh_col", int'(sel_col), 4);
        chk("thresh_row", int'(sel_row), 3);
        x_v = 10'd512; y_v = 10'd512;
        tick(3);

        // btnC rising edge -> exactly one pulse, one cycle later
        c_v = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk("btnc_pulse", int'(place_pulse), (i == 1) ? 1 : 0);
        end
        c_v = 1'b0;
        tick(3);

        // btnZ held for 50 cycles -> one fire pulse
        z_v = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            cnt += int'(fire_pulse);
        end
        chk("btnz_held_fires", cnt, 1);
        z_v = 1'b0;
        tick(3);

        // btnC rise coincident with accepted btnr rise -> single pulse
        btnr = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 6) c_v = 1'b1;
            tick(1);
            cnt += int'(place_pulse);
            if (i == 6) chk("coincident_at", int'(place_pulse), 1);
        end
        chk("coincident_count", cnt, 1);
        c_v = 1'b0; btnr = 1'b0;
        tick(10);

        // Bouncing btnr then stable: pulse 6 cycles after the final stable edge
        btnr = 1'b1; tick(1);
        btnr = 1'b0; tick(1);
        btnr = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            chk("bounce_pulse", int'(place_pulse), (i == 6) ? 1 : 0);
        end
        btnr = 1'b0;
        tick(10);

        // Short glitch is rejected
        btnr = 1'b1; tick(2);
        btnr = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            cnt += int'(place_pulse);
        end
        chk("glitch_pulses", cnt, 0);

        // Disabled: no movement, no pulses
        enable = 1'b0; x_v = 10'd100;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            c_v = ~c_v;
            tick(1);
            cnt += int'(place_pulse) + int'(fire_pulse);
        end
        chk("disabled_col", int'(sel_col), 4);
        chk("disabled_pulses", cnt, 0);
        c_v = 1'b1;
        tick(2);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk("enable_col", int'(sel_col), (i >= 2) ? 3 : 4);
            chk("enable_no_pulse", int'(place_pulse), 0);
        end
        c_v = 1'b0; x_v = 10'd512;
        tick(3);

        // Randomized traffic checked by the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 5))
                    0: x_v = 10'd512;
                    1: x_v = 10'd100;
                    2: x_v = 10'd900;
                    3: x_v = 10'($urandom_range(349, 351));
                    4: x_v = 10'($urandom_range(649, 651));
                    default: x_v = 10'($urandom_range(0, 1023));
                endcase
            end
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: y_v = 10'd512;
                    1: y_v = 10'd50;
                    2: y_v = 10'd1000;
                    default: y_v = 10'($urandom_range(0, 1023));
                endcase
            end
            if ($urandom_range(0, 3) == 0) c_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) z_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) btnr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
